// File: rtl/fsk_symbol_sequencer.sv
// Frame sequencer for an FSK modulator: fetches payload bytes over valid/ready,
// prepends an alternating preamble and emits one bit per symbol, LSB-first.
module fsk_symbol_sequencer #(
  parameter int PREAMBLE_BITS = 8,
  parameter int LEN_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             symDone,
  output logic             symVal,
  output logic             mod_rst,
  output logic             busy,
  output logic             tx_done,
  output logic             underrun,
  output logic [2:0]       state_o
);
  // Byte stream: a byte transfers on any clock where byte_valid & byte_ready are both high.
  localparam int   PW   = $clog2(PREAMBLE_BITS);
  localparam logic PODD = (PREAMBLE_BITS % 2) == 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PREAMBLE = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fetched_q, fetched_d;
  logic [LEN_W-1:0] sent_q, sent_d;
  logic             sym_q, sym_d;
  logic             mod_rst_q, mod_rst_d;
  logic             busy_q, busy_d;
  logic             tx_done_q, tx_done_d;
  logic             underrun_q, underrun_d;
  logic             xfer;

  assign byte_ready = (state_q inside {S_LOAD, S_PREAMBLE, S_PAYLOAD}) &&
                      !hold_full_q && (fetched_q < len_q);
  assign xfer       = byte_valid && byte_ready;

  assign symVal   = sym_q;
  assign mod_rst  = mod_rst_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;
  assign underrun = underrun_q;
  assign state_o  = state_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_idx_d   = bit_idx_q;
    pre_cnt_d   = pre_cnt_q;
    len_d       = len_q;
    fetched_d   = fetched_q;
    sent_d      = sent_q;
    sym_d       = sym_q;
    mod_rst_d   = mod_rst_q;
    busy_d      = busy_q;
    tx_done_d   = 1'b0;
    underrun_d  = 1'b0;

    if (xfer) begin
      hold_d      = byte_data;
      hold_full_d = 1'b1;
      fetched_d   = fetched_q + LEN_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            len_d       = len;
            busy_d      = 1'b1;
            hold_full_d = 1'b0;
            fetched_d   = '0;
            sent_d      = '0;
            pre_cnt_d   = '0;
            bit_idx_d   = '0;
            state_d     = S_LOAD;
          end else begin
            tx_done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        // First preamble bit is chosen so the last preamble bit is ~byte0[0].
        if (xfer) begin
          mod_rst_d = 1'b1;
          sym_d     = byte_data[0] ^ PODD;
          pre_cnt_d = '0;
          state_d   = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (symDone) begin
          if (pre_cnt_q != PW'(PREAMBLE_BITS - 1)) begin
            pre_cnt_d = pre_cnt_q + PW'(1);
            sym_d     = ~sym_q;
          end else begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            sym_d       = hold_q[0];
            bit_idx_d   = '0;
            sent_d      = sent_q + LEN_W'(1);
            state_d     = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (symDone) begin
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            sym_d     = shift_q[1];
          end else if (sent_q == len_q) begin
            tx_done_d = 1'b1;
            mod_rst_d = 1'b0;
            sym_d     = 1'b0;
            busy_d    = 1'b0;
            state_d   = S_DONE;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            sym_d       = hold_q[0];
            bit_idx_d   = '0;
            sent_d      = sent_q + LEN_W'(1);
          end else begin
            underrun_d  = 1'b1;
            mod_rst_d   = 1'b0;
            sym_d       = 1'b0;
            busy_d      = 1'b0;
            hold_full_d = 1'b0;
            fetched_d   = '0;
            sent_d      = '0;
            pre_cnt_d   = '0;
            bit_idx_d   = '0;
            state_d     = S_IDLE;
          end
        end
      end
      S_DONE: begin
        fetched_d = '0;
        sent_d    = '0;
        pre_cnt_d = '0;
        bit_idx_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_idx_q   <= '0;
      pre_cnt_q   <= '0;
      len_q       <= '0;
      fetched_q   <= '0;
      sent_q      <= '0;
      sym_q       <= 1'b0;
      mod_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_idx_q   <= bit_idx_d;
      pre_cnt_q   <= pre_cnt_d;
      len_q       <= len_d;
      fetched_q   <= fetched_d;
      sent_q      <= sent_d;
      sym_q       <= sym_d;
      mod_rst_q   <= mod_rst_d;
      busy_q      <= busy_d;
      tx_done_q   <= tx_done_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule
